// File: rtl/multi_port_ram_arbiter.sv
// ----------------------------------------------------------------------------
// multi_port_ram_arbiter
//
// Shares one single-port synchronous RAM between NUM_MASTERS requesters.
// One access is granted per cycle, either by fixed priority (MODE 0, master 0
// highest) or by round-robin with a burst limit (MODE 1). The granted access
// is registered onto the RAM port. A tag pipeline follows every read through
// the RAM latency, so the read data can be steered back to the master that
// issued it.
//
// Ports
//   clk          single clock, rising edge
//   rst          asynchronous, active-low reset
//   req          per-master access request
//   WE           per-master write enable (qualified by req)
//   address      flattened addresses, master i at [i*ADDRESS_WIDTH +: ADDRESS_WIDTH]
//   wdata        flattened write data, master i at [i*DATA_WIDTH +: DATA_WIDTH]
//   gnt          one-hot/zero grant, combinational in the request cycle
//   rvalid       one-hot/zero read-data-valid strobe
//   rdata        read data shared by all masters, held between strobes
//   ram_CE       registered RAM chip enable
//   ram_WE       registered RAM write enable
//   ram_address  registered RAM address
//   ram_wdata    registered RAM write data
//   ram_rdata    RAM read data, valid READ_LATENCY cycles after ram_CE
// ----------------------------------------------------------------------------
module multi_port_ram_arbiter #(
   parameter int NUM_MASTERS   = 2,
   parameter int DATA_WIDTH    = 8,
   parameter int ADDRESS_WIDTH = 17,
   parameter int MODE          = 0,
   parameter int MAX_BURST     = 4,
   parameter int READ_LATENCY  = 1
) (
   input  logic                                 clk,
   input  logic                                 rst,
   input  logic [NUM_MASTERS-1:0]               req,
   input  logic [NUM_MASTERS-1:0]               WE,
   input  logic [NUM_MASTERS*ADDRESS_WIDTH-1:0] address,
   input  logic [NUM_MASTERS*DATA_WIDTH-1:0]    wdata,
   output logic [NUM_MASTERS-1:0]               gnt,
   output logic [NUM_MASTERS-1:0]               rvalid,
   output logic [DATA_WIDTH-1:0]                rdata,
   output logic                                 ram_CE,
   output logic                                 ram_WE,
   output logic [ADDRESS_WIDTH-1:0]             ram_address,
   output logic [DATA_WIDTH-1:0]                ram_wdata,
   input  logic [DATA_WIDTH-1:0]                ram_rdata
);

   localparam int IDX_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
   localparam int CNT_W = $clog2(MAX_BURST + 1);

   // Arbitration state (round-robin only; harmless in fixed-priority mode)
   logic [IDX_W-1:0] owner;
   logic [CNT_W-1:0] burst_count;

   // Winner of the current cycle
   logic             win_vld;
   logic [IDX_W-1:0] win_idx;
   logic [IDX_W-1:0] cand;

   // Registered access and read-tag pipeline
   logic [IDX_W-1:0]      reg_idx;
   logic                  tag_vld [READ_LATENCY];
   logic [IDX_W-1:0]      tag_idx [READ_LATENCY];
   logic [DATA_WIDTH-1:0] rdata_q;

   // -------------------------------------------------------------------------
   // Arbitration
   // -------------------------------------------------------------------------
   // NOTE: every signal written in an always_comb gets a default on entry, so
   // no path leaves it unassigned and no latch is inferred.
   always_comb begin
      win_vld = 1'b0;
      win_idx = '0;
      cand    = '0;
      if (MODE == 0) begin
         // Descending scan: the last hit, i.e. the lowest index, wins.
         for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
            if (req[i]) begin
               win_vld = 1'b1;
               win_idx = IDX_W'(i);
            end
         end
      end else if (burst_count != '0 && burst_count < CNT_W'(MAX_BURST) && req[owner]) begin
         // A zero count means the owner did not hold the previous cycle, so a
         // fresh search starts from owner+1 (this is what makes master 0 first
         // after reset).
         win_vld = 1'b1;
         win_idx = owner;
      end else begin
         // Search owner+1 .. owner (wrapping). Scanning from the far end keeps
         // the nearest requester as the final assignment. The owner itself is
         // the last candidate, so a lone owner keeps its grant past MAX_BURST.
         for (int k = NUM_MASTERS; k >= 1; k--) begin
            cand = IDX_W'((int'(owner) + k) % NUM_MASTERS);
            if (req[cand]) begin
               win_vld = 1'b1;
               win_idx = cand;
            end
         end
      end
   end

   // Grant is forced low during reset
   always_comb begin
      gnt = '0;
      if (rst && win_vld) gnt[win_idx] = 1'b1;
   end

   // -------------------------------------------------------------------------
   // Registered RAM access, burst tracking and read-tag pipeline
   // -------------------------------------------------------------------------
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ram_CE      <= 1'b0;
         ram_WE      <= 1'b0;
         ram_address <= '0;
         ram_wdata   <= '0;
         reg_idx     <= '0;
         owner       <= IDX_W'(NUM_MASTERS - 1);
         burst_count <= '0;
         rdata_q     <= '0;
         // NOTE: the tag pipeline is reset (it is a few flops, not a RAM) so
         // reads in flight at reset never produce an rvalid afterwards.
         for (int s = 0; s < READ_LATENCY; s++) begin
            tag_vld[s] <= 1'b0;
            tag_idx[s] <= '0;
         end
      end else begin
         ram_CE <= win_vld;
         ram_WE <= win_vld & WE[win_idx];
         if (win_vld) begin
            ram_address <= address[int'(win_idx)*ADDRESS_WIDTH +: ADDRESS_WIDTH];
            ram_wdata   <= wdata[int'(win_idx)*DATA_WIDTH +: DATA_WIDTH];
            reg_idx     <= win_idx;
            owner       <= win_idx;
            if (win_idx == owner) begin
               if (burst_count < CNT_W'(MAX_BURST)) burst_count <= burst_count + CNT_W'(1);
            end else begin
               burst_count <= CNT_W'(1);
            end
         end else begin
            // Idle cycle breaks the burst; owner is kept as the search origin.
            burst_count <= '0;
         end

         // Tag stage 0 follows the registered access; only reads are flagged.
         tag_vld[0] <= ram_CE & ~ram_WE;
         tag_idx[0] <= reg_idx;
         for (int s = 1; s < READ_LATENCY; s++) begin
            tag_vld[s] <= tag_vld[s-1];
            tag_idx[s] <= tag_idx[s-1];
         end

         if (tag_vld[READ_LATENCY-1]) rdata_q <= ram_rdata;
      end
   end

   // The last tag stage lines up with ram_rdata: pass it through in the strobe
   // cycle and hold the captured copy otherwise.
   always_comb begin
      rvalid = '0;
      rdata  = rdata_q;
      if (tag_vld[READ_LATENCY-1]) begin
         rvalid[tag_idx[READ_LATENCY-1]] = 1'b1;
         rdata                           = ram_rdata;
      end
   end

endmodule

// File: tb/tb_multi_port_ram_arbiter.sv
// ----------------------------------------------------------------------------
// tb_multi_port_ram_arbiter
//
// Two instances share clock and reset:
//   dut_a : MODE 0, 2 masters, READ_LATENCY 3
//   dut_b : MODE 1, 3 masters, MAX_BURST 2, READ_LATENCY 2
// Each has a behavioural RAM model. Expected reads are queued when the
// stimulus is driven and popped by a per-instance monitor on rvalid.
// ----------------------------------------------------------------------------
module tb_multi_port_ram_arbiter;

   localparam int AW   = 17;
   localparam int DW   = 8;
   localparam int RL_A = 3;
   localparam int RL_B = 2;

   typedef struct {
      int          cyc;
      int          m;
      logic [7:0]  d;
   } exp_t;

   logic clk;
   logic rst;

   // dut_a signals
   logic [1:0]      a_req, a_we, a_gnt, a_rvalid;
   logic [2*AW-1:0] a_addr;
   logic [2*DW-1:0] a_wdata;
   logic [DW-1:0]   a_rdata, a_rwd, a_rrd;
   logic            a_ce, a_rwe;
   logic [AW-1:0]   a_raddr;

   // dut_b signals
   logic [2:0]      b_req, b_we, b_gnt, b_rvalid;
   logic [3*AW-1:0] b_addr;
   logic [3*DW-1:0] b_wdata;
   logic [DW-1:0]   b_rdata, b_rwd, b_rrd;
   logic            b_ce, b_rwe;
   logic [AW-1:0]   b_raddr;

   int   cyc    = 0;
   int   n_cmp  = 0;
   int   n_bad  = 0;
   logic mon_en = 1'b0;
   logic [7:0] last_a = 8'h00;
   logic [7:0] last_b = 8'h00;
   exp_t q_a[$];
   exp_t q_b[$];

   multi_port_ram_arbiter #(
      .NUM_MASTERS(2), .DATA_WIDTH(DW), .ADDRESS_WIDTH(AW),
      .MODE(0), .MAX_BURST(4), .READ_LATENCY(RL_A)
   ) dut_a (
      .clk(clk), .rst(rst), .req(a_req), .WE(a_we), .address(a_addr),
      .wdata(a_wdata), .gnt(a_gnt), .rvalid(a_rvalid), .rdata(a_rdata),
      .ram_CE(a_ce), .ram_WE(a_rwe), .ram_address(a_raddr),
      .ram_wdata(a_rwd), .ram_rdata(a_rrd)
   );

   multi_port_ram_arbiter #(
      .NUM_MASTERS(3), .DATA_WIDTH(DW), .ADDRESS_WIDTH(AW),
      .MODE(1), .MAX_BURST(2), .READ_LATENCY(RL_B)
   ) dut_b (
      .clk(clk), .rst(rst), .req(b_req), .WE(b_we), .address(b_addr),
      .wdata(b_wdata), .gnt(b_gnt), .rvalid(b_rvalid), .rdata(b_rdata),
      .ram_CE(b_ce), .ram_WE(b_rwe), .ram_address(b_raddr),
      .ram_wdata(b_rwd), .ram_rdata(b_rrd)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // ---------------------------------------------------------------------
   // RAM models: data appears READ_LATENCY cycles after ram_CE; random
   // filler when not reading so a missing rdata hold shows up.
   // ---------------------------------------------------------------------
   logic [7:0] mem_a [256];
   logic [7:0] mem_b [256];
   logic [7:0] a_pipe [RL_A];
   logic [7:0] b_pipe [RL_B];

   initial begin
      for (int i = 0; i < 256; i++) begin
         mem_a[i] = 8'(i) ^ 8'h5A;
         mem_b[i] = 8'(i) ^ 8'hA3;
      end
      for (int i = 0; i < RL_A; i++) a_pipe[i] = 8'h00;
      for (int i = 0; i < RL_B; i++) b_pipe[i] = 8'h00;
   end

   always @(posedge clk) begin
      if (a_ce && a_rwe) mem_a[a_raddr[7:0]] <= a_rwd;
      a_pipe[0] <= (a_ce && !a_rwe) ? mem_a[a_raddr[7:0]] : 8'($urandom);
      for (int i = 1; i < RL_A; i++) a_pipe[i] <= a_pipe[i-1];
      if (b_ce && b_rwe) mem_b[b_raddr[7:0]] <= b_rwd;
      b_pipe[0] <= (b_ce && !b_rwe) ? mem_b[b_raddr[7:0]] : 8'($urandom);
      for (int i = 1; i < RL_B; i++) b_pipe[i] <= b_pipe[i-1];
   end

   assign a_rrd = a_pipe[RL_A-1];
   assign b_rrd = b_pipe[RL_B-1];

   // ---------------------------------------------------------------------
   // Scoreboard monitors (sample on the falling edge)
   // ---------------------------------------------------------------------
   always @(negedge clk) begin
      exp_t e;
      if (mon_en) begin
         if (a_rvalid !== 2'b00) begin
            n_cmp++;
            if (q_a.size() == 0) begin
               n_bad++;
               $display("FAIL a_unexpected_rvalid: cycle %0d got rvalid=%b, required none", cyc, a_rvalid);
            end else begin
               e = q_a.pop_front();
               if (a_rvalid !== 2'(1 << e.m) || a_rdata !== e.d || cyc != e.cyc) begin
                  n_bad++;
                  $display("FAIL a_read: cycle %0d got rvalid=%b rdata=%h, required cycle %0d rvalid=%b rdata=%h",
                           cyc, a_rvalid, a_rdata, e.cyc, 2'(1 << e.m), e.d);
               end
               last_a = e.d;
            end
         end else begin
            n_cmp++;
            if (a_rdata !== last_a) begin
               n_bad++;
               $display("FAIL a_rdata_hold: cycle %0d got rdata=%h, required %h", cyc, a_rdata, last_a);
            end
            if (q_a.size() != 0 && q_a[0].cyc <= cyc) begin
               n_cmp++;
               n_bad++;
               $display("FAIL a_missed_rvalid: cycle %0d got rvalid=00, required master %0d", cyc, q_a[0].m);
               void'(q_a.pop_front());
            end
         end
      end
   end

   always @(negedge clk) begin
      exp_t e;
      if (mon_en) begin
         if (b_rvalid !== 3'b000) begin
            n_cmp++;
            if (q_b.size() == 0) begin
               n_bad++;
               $display("FAIL b_unexpected_rvalid: cycle %0d got rvalid=%b, required none", cyc, b_rvalid);
            end else begin
               e = q_b.pop_front();
               if (b_rvalid !== 3'(1 << e.m) || b_rdata !== e.d || cyc != e.cyc) begin
                  n_bad++;
                  $display("FAIL b_read: cycle %0d got rvalid=%b rdata=%h, required cycle %0d rvalid=%b rdata=%h",
                           cyc, b_rvalid, b_rdata, e.cyc, 3'(1 << e.m), e.d);
               end
               last_b = e.d;
            end
         end else begin
            n_cmp++;
            if (b_rdata !== last_b) begin
               n_bad++;
               $display("FAIL b_rdata_hold: cycle %0d got rdata=%h, required %h", cyc, b_rdata, last_b);
            end
            if (q_b.size() != 0 && q_b[0].cyc <= cyc) begin
               n_cmp++;
               n_bad++;
               $display("FAIL b_missed_rvalid: cycle %0d got rvalid=000, required master %0d", cyc, q_b[0].m);
               void'(q_b.pop_front());
            end
         end
      end
   end

   // Drive point: just after the rising edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // ---------------------------------------------------------------------
   // Scenarios
   // ---------------------------------------------------------------------
   task automatic test_reset();
      rst = 1'b0;
      a_req = 2'b11;  a_we = 2'b00; a_addr = '0; a_wdata = '0;
      b_req = 3'b111; b_we = 3'b000; b_addr = '0; b_wdata = '0;
      repeat (2) @(negedge clk);
      n_cmp++;
      if ({a_gnt, b_gnt} !== 5'b0) begin
         n_bad++;
         $display("FAIL reset_gnt: got a_gnt=%b b_gnt=%b, required all zero", a_gnt, b_gnt);
      end
      n_cmp++;
      if (a_ce !== 1'b0 || b_ce !== 1'b0 || a_rwe !== 1'b0 || b_rwe !== 1'b0 ||
          a_rvalid !== 2'b0 || b_rvalid !== 3'b0 || a_rdata !== 8'h0 || b_rdata !== 8'h0 ||
          a_raddr !== '0 || b_raddr !== '0 || a_rwd !== 8'h0 || b_rwd !== 8'h0) begin
         n_bad++;
         $display("FAIL reset_outputs: got a_ce=%b b_ce=%b a_rvalid=%b b_rvalid=%b a_rdata=%h b_rdata=%h, required all zero",
                  a_ce, b_ce, a_rvalid, b_rvalid, a_rdata, b_rdata);
      end
      a_req = 2'b00;
      b_req = 3'b000;
      tick();
      rst    = 1'b1;
      mon_en = 1'b1;
      tick();
   endtask

   task automatic test_fixed_priority();
      a_addr = {17'h00022, 17'h00011};
      a_we   = 2'b00;
      for (int i = 0; i < 4; i++) begin
         a_req = (i < 3) ? 2'b11 : 2'b00;
         if (i < 3) q_a.push_back('{cyc: cyc + 1 + RL_A, m: 0, d: mem_a[8'h11]});
         @(negedge clk);
         if (i < 3) begin
            n_cmp++;
            if (a_gnt !== 2'b01) begin
               n_bad++;
               $display("FAIL fixed_gnt: step %0d got gnt=%b, required 01", i, a_gnt);
            end
         end
         if (i > 0) begin
            n_cmp++;
            if (a_ce !== 1'b1 || a_raddr !== 17'h00011) begin
               n_bad++;
               $display("FAIL fixed_ram_addr: step %0d got ce=%b addr=%h, required ce=1 addr=00011", i, a_ce, a_raddr);
            end
         end
         tick();
      end
      // Only master 1 requesting
      a_req = 2'b10;
      q_a.push_back('{cyc: cyc + 1 + RL_A, m: 1, d: mem_a[8'h22]});
      @(negedge clk);
      n_cmp++;
      if (a_gnt !== 2'b10) begin
         n_bad++;
         $display("FAIL fixed_gnt_m1: got gnt=%b, required 10", a_gnt);
      end
      tick();
      a_req = 2'b00;
      repeat (6) tick();
   endtask

   task automatic test_read_latency();
      // Master 0 raises WE without req; it must be ignored.
      a_addr = {17'h000A5, 17'h1FFFF};
      a_we   = 2'b01;
      a_req  = 2'b10;
      q_a.push_back('{cyc: cyc + 1 + RL_A, m: 1, d: mem_a[8'hA5]});
      @(negedge clk);
      n_cmp++;
      if (a_gnt !== 2'b10) begin
         n_bad++;
         $display("FAIL latency_gnt: got gnt=%b, required 10", a_gnt);
      end
      tick();
      a_req = 2'b00;
      a_we  = 2'b00;
      @(negedge clk);
      n_cmp++;
      if (a_ce !== 1'b1 || a_rwe !== 1'b0 || a_raddr !== 17'h000A5) begin
         n_bad++;
         $display("FAIL latency_ram: got ce=%b we=%b addr=%h, required ce=1 we=0 addr=000a5", a_ce, a_rwe, a_raddr);
      end
      repeat (6) tick();
   endtask

   task automatic test_back_to_back();
      a_we   = 2'b00;
      a_addr = {17'h00000, 17'h00010};
      a_req  = 2'b01;
      q_a.push_back('{cyc: cyc + 1 + RL_A, m: 0, d: mem_a[8'h10]});
      tick();
      a_addr = {17'h00020, 17'h00000};
      a_req  = 2'b10;
      q_a.push_back('{cyc: cyc + 1 + RL_A, m: 1, d: mem_a[8'h20]});
      tick();
      a_addr  = {17'h00077, 17'h00030};
      a_wdata = {8'hEE, 8'hC3};
      a_we    = 2'b11;
      a_req   = 2'b01;
      tick();
      a_req = 2'b00;
      a_we  = 2'b00;
      @(negedge clk);
      n_cmp++;
      if (a_ce !== 1'b1 || a_rwe !== 1'b1 || a_raddr !== 17'h00030 || a_rwd !== 8'hC3) begin
         n_bad++;
         $display("FAIL write_ram: got ce=%b we=%b addr=%h wdata=%h, required 1 1 00030 c3", a_ce, a_rwe, a_raddr, a_rwd);
      end
      repeat (6) tick();
      // Read the written word back through master 1
      a_addr = {17'h00030, 17'h00000};
      a_req  = 2'b10;
      q_a.push_back('{cyc: cyc + 1 + RL_A, m: 1, d: 8'hC3});
      tick();
      a_req = 2'b00;
      repeat (6) tick();
   endtask

   task automatic test_round_robin();
      int seq [6] = '{0, 0, 1, 1, 2, 2};
      b_addr = {17'h00003, 17'h00002, 17'h00001};
      b_we   = 3'b000;
      for (int i = 0; i < 6; i++) begin
         b_req = 3'b111;
         q_b.push_back('{cyc: cyc + 1 + RL_B, m: seq[i], d: mem_b[8'(seq[i] + 1)]});
         @(negedge clk);
         n_cmp++;
         if (b_gnt !== 3'(1 << seq[i])) begin
            n_bad++;
            $display("FAIL rr_gnt: step %0d got gnt=%b, required %b", i, b_gnt, 3'(1 << seq[i]));
         end
         tick();
      end
      b_req = 3'b000;
      tick();
      // Lone requester keeps the grant past MAX_BURST
      for (int i = 0; i < 5; i++) begin
         b_req = 3'b010;
         q_b.push_back('{cyc: cyc + 1 + RL_B, m: 1, d: mem_b[8'h02]});
         @(negedge clk);
         n_cmp++;
         if (b_gnt !== 3'b010) begin
            n_bad++;
            $display("FAIL rr_lone_gnt: step %0d got gnt=%b, required 010", i, b_gnt);
         end
         tick();
      end
      b_req = 3'b000;
      repeat (5) tick();
   endtask

   task automatic test_reset_mid_read();
      b_addr  = {17'h00000, 17'h00000, 17'h00005};
      b_wdata = {8'h11, 8'h22, 8'h33};
      b_req   = 3'b001;
      tick();
      b_req = 3'b000;
      #2;
      rst    = 1'b0;
      last_a = 8'h00;
      last_b = 8'h00;
      b_req  = 3'b111;
      #1;
      n_cmp++;
      if (b_ce !== 1'b0 || b_rwe !== 1'b0 || b_raddr !== '0 || b_rwd !== 8'h0 ||
          b_rdata !== 8'h0 || b_rvalid !== 3'b0 || b_gnt !== 3'b0) begin
         n_bad++;
         $display("FAIL midreset_outputs: got ce=%b we=%b addr=%h wdata=%h rdata=%h rvalid=%b gnt=%b, required all zero",
                  b_ce, b_rwe, b_raddr, b_rwd, b_rdata, b_rvalid, b_gnt);
      end
      repeat (2) tick();
      b_req = 3'b000;
      rst   = 1'b1;
      repeat (6) tick();
   endtask

   // ---------------------------------------------------------------------
   initial begin
      test_reset();
      test_fixed_priority();
      test_read_latency();
      test_back_to_back();
      test_round_robin();
      test_reset_mid_read();
      repeat (4) tick();
      n_cmp++;
      if (q_a.size() + q_b.size() != 0) begin
         n_bad++;
         $display("FAIL drain: got %0d reads outstanding, required 0", q_a.size() + q_b.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got no completion by time limit, required completion");
      $fatal(1, "time limit reached");
   end

endmodule

// File: doc/multi_port_ram_arbiter.md
MULTI_PORT_RAM_ARBITER -- requirements
Module: multi_port_ram_arbiter

Interface
REQ-001 SHALL have parameter NUM_MASTERS, default 2, meaning number of requesting masters (legal 2..8).
REQ-002 SHALL have parameter DATA_WIDTH, default 8, meaning RAM word width.
REQ-003 SHALL have parameter ADDRESS_WIDTH, default 17, meaning RAM address width.
REQ-004 SHALL have parameter MODE, default 0, meaning 0 = fixed priority (index 0 highest), 1 = round-robin.
REQ-005 SHALL have parameter MAX_BURST, default 4, meaning maximum consecutive grants to one master in round-robin mode (legal 1..16).
REQ-006 SHALL have parameter READ_LATENCY, default 1, meaning cycles from ram_CE registered high to ram_rdata valid (legal 1..4).
REQ-007 SHALL have ports: clk  in  1  single clock, all logic on rising edge.
REQ-008 SHALL have ports: rst  in  1  asynchronous, active-low reset.
REQ-009 SHALL have ports: req  in  NUM_MASTERS  per-master access request.
REQ-010 SHALL have ports: WE  in  NUM_MASTERS  per-master write enable, qualified by req.
REQ-011 SHALL have ports: address  in  NUM_MASTERS*ADDRESS_WIDTH  flattened, master i at slice i.
REQ-012 SHALL have ports: wdata  in  NUM_MASTERS*DATA_WIDTH  flattened write data.
REQ-013 SHALL have ports: gnt  out  NUM_MASTERS  one-hot/zero grant, combinational in request cycle.
REQ-014 SHALL have ports: rvalid  out  NUM_MASTERS  one-hot/zero read-data-valid strobe.
REQ-015 SHALL have ports: rdata  out  DATA_WIDTH  read data shared by all masters.
REQ-016 SHALL have ports: ram_CE, ram_WE  out  1 each; ram_address  out  ADDRESS_WIDTH; ram_wdata  out  DATA_WIDTH; ram_rdata  in  DATA_WIDTH.

Function
REQ-017 SHALL assert at most one gnt bit per cycle, and only for a master with req high.
REQ-018 SHALL, in MODE 0, grant the lowest-index requesting master every cycle.
REQ-019 SHALL, in MODE 1, keep the owner granted while its req stays high and burst_count < MAX_BURST; otherwise grant the first requester searching from owner+1 with wrap-around (NUM_MASTERS-1 -> 0).
REQ-020 SHALL increment burst_count on each consecutive grant to the same master, and reload it to 1 on an owner change; if no other master requests, the owner stays granted past MAX_BURST and burst_count saturates.
REQ-021 SHALL register the granted access: at the next edge, ram_CE=1, ram_WE=WE[i], ram_address/ram_wdata = slice i; with no grant, ram_CE=0 and ram_WE=0.
REQ-022 SHALL push the granted index and a read flag (ram_CE & ~ram_WE) into a READ_LATENCY-deep tag pipeline.
REQ-023 SHALL pulse rvalid[i] for one cycle with rdata=ram_rdata exactly READ_LATENCY cycles after the registered read cycle; writes produce no rvalid.
REQ-024 SHALL sustain one access per cycle, including back-to-back reads from different masters, with rvalid order equal to grant order.
REQ-025 SHALL hold rdata at its last value when no rvalid is asserted.
REQ-026 SHALL ignore WE, address and wdata of non-granted masters.
REQ-027 SHALL treat a req deasserted by the owner as releasing ownership in that cycle.

Reset
REQ-028 SHALL, on rst low, immediately clear ram_CE, ram_WE, ram_address, ram_wdata, rdata, rvalid, the tag pipeline and burst_count, and set the round-robin owner pointer to NUM_MASTERS-1 (so master 0 is searched first).
REQ-029 SHALL discard in-flight reads on reset; no rvalid is issued for them after rst returns high.
REQ-030 SHALL keep gnt at zero while rst is low.

Verification
REQ-031 Fixed priority: MODE=0, req=2'b11 for 3 cycles -> gnt=2'b01 every cycle; ram_address follows master 0 one cycle later.
REQ-032 Round-robin burst: MODE=1, MAX_BURST=2, NUM_MASTERS=3, req=3'b111 for 6 cycles -> gnt sequence 0,0,1,1,2,2.
REQ-033 Lone requester: MODE=1, MAX_BURST=2, only req[1] high for 5 cycles -> gnt[1] high all 5 cycles.
REQ-034 Read latency: READ_LATENCY=3, master 1 reads address 0x00A5 at cycle t -> ram_CE/ram_address=0x00A5 at t+1, rvalid=2'b10 with rdata=ram_rdata at t+4.
REQ-035 Interleave: reads m0@0x10, m1@0x20 back-to-back, write m0@0x30 -> rvalid m0 then m1 on consecutive cycles, no rvalid for the write.
REQ-036 Reset mid-read: READ_LATENCY=2, assert rst low one cycle after a read grant -> all outputs 0 immediately, no rvalid after release.
